m2_fdct_block_encoder: RTL and testbench
========================================

// Module: m2_fdct_block_encoder
// PURPOSE
//  Forward 2-D 8x8 DCT: the encode-side counterpart of the Milestone 2 IDCT datapath.
//  Per Start pulse, reads one 8x8 block of 8-bit pixels (two pixels per 16-bit word) from
//  external SRAM, computes S' = C*S*C^T in fixed point, and writes 64 signed 16-bit
//  coefficients back into the pre-IDCT region. The output feeds the decompressor test flow.
// PARAMETERS
//  C_FRAC   12  fractional bits of the C table (C[k][n] = round(4096*a_k*cos((2n+1)k*pi/16)))
//  SHIFT1    8  arithmetic right shift applied to each stage-1 (T) accumulation
//  SHIFT2   16  arithmetic right shift applied to each stage-2 (S') accumulation
// PORTS
//  Clock            in   1   system clock, all state on rising edge
//  Reset            in   1   synchronous, active-high reset
//  Start            in   1   one-cycle request; sampled only in S_IDLE
//  Pixel_base       in  18   SRAM word address of block row 0, word 0
//  Pixel_stride     in   9   words between pixel rows (160 for Y, 80 for U/V)
//  Coeff_base       in  18   SRAM address of coefficient S'[0][0]
//  Coeff_stride     in   9   words between coefficient rows (320 for Y, 160 for U/V)
//  SRAM_address     out 18   SRAM address, registered
//  SRAM_read_data   in  16   {pixel 2w [15:8], pixel 2w+1 [7:0]}; valid 2 cycles after address
//  SRAM_write_data  out 16   coefficient, two's complement, registered
//  SRAM_we_n        out  1   active-low write enable, registered
//  Busy             out  1   high from the edge after Start is accepted until Done
//  Done             out  1   one-cycle pulse when the last coefficient has been written
// BEHAVIOUR
//  Reset: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, Busy=0, Done=0, state S_IDLE.
//   Reset takes effect mid-operation too: no further SRAM writes, and buffers are don't-care.
//  Inputs Pixel_*/Coeff_* are latched on the Start edge E0. Start while Busy is ignored.
//  States:
//   S_IDLE -> S_FETCH on Start.
//   S_FETCH: edges E1..E32 issue reads at Pixel_base + r*Pixel_stride + w
//    (r=0..7, w=0..3, r-major). Data is captured at E3..E34 into S[r][2w], S[r][2w+1]
//    (unsigned 8-bit, zero-extended).
//   S_FETCH_DRAIN covers E33..E34.
//   S_CT (E35..E546): T[r][k] = sat16((sum_n S[r][n]*C[k][n]) >>> SHIFT1). One MAC per
//    cycle; 8 cycles per element; order r-major, k-minor. T is held in 64x16 internal storage.
//   S_CS (E547..E1058): S'[k][c] = sat16((sum_r C[k][r]*T[r][c]) >>> SHIFT2). One MAC per
//    cycle; order k-major, c-minor. On the edge after each element's 8th MAC, drive
//    SRAM_we_n=0, address = Coeff_base + k*Coeff_stride + c, data = S'[k][c].
//    First write is at E555; the 64th (last) write is at E1059. SRAM_we_n returns to 1 on
//    the next edge unless another write is due.
//   S_DONE: at E1060, Done=1 for one cycle, Busy=0, then S_IDLE. Total latency is 1060 cycles.
//  Arithmetic:
//   Products are signed 32-bit. Accumulators are 32-bit signed; no overflow is possible
//    for the given C.
//   >>> is floor (arithmetic) shift. sat16 clamps to [-32768, 32767].
//  C table: a_0 = sqrt(1/8), a_k = sqrt(2/8) for k>0, entries signed 13-bit. It is identical
//   to the IDCT's C ROM, with the transpose taken by swapping indices.
//  SRAM_address holds its last value when idle. No reads are issued during S_CT/S_CS.
// TESTING
//  1. All-zero block, Coeff_base=76800, Coeff_stride=320 -> 64 writes of 0, the first at E555.
//     Done is at E1060.
//  2. All pixels 255 (words 16'hFFFF) -> S'[0][0]=2039; all other 63 coefficients are exactly 0.
//  3. All pixels 128 (16'h8080) -> S'[0][0]=1023; the rest are 0. Check T[r][0]=5792 via
//     hierarchical peek.
//  4. Pixel_base=4, Pixel_stride=160 -> read addresses 4,5,6,7,164..167,...,1124..1127.
//     Write addresses are Coeff_base+k*320+c in k-major order.
//  5. Start pulsed again at E100 -> ignored; the write sequence and Done timing are unchanged.
//  6. Reset asserted at E600 -> from the next edge SRAM_we_n=1, Busy=0, no writes.
//     A new Start afterwards gives a correct full block with Done 1060 cycles later.

Source files
------------

// File: rtl/m2_fdct_block_encoder.sv
// Forward 8x8 DCT block encoder: fetches one pixel block from SRAM, computes C*S*C^T
// with a single shared MAC, and writes 64 signed 16-bit coefficients back to SRAM.
module m2_fdct_block_encoder (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Pixel_base,
    input  logic [8:0]  Pixel_stride,
    input  logic [17:0] Coeff_base,
    input  logic [8:0]  Coeff_stride,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FETCH_DRAIN, S_CT, S_CS, S_DONE
    } state_t;

    state_t             state;
    logic [10:0]        cyc;
    logic [17:0]        pix_base, coef_base;
    logic [8:0]         pix_stride, coef_stride;

    logic [7:0]         s_mem [0:63];
    logic signed [15:0] t_mem [0:63];
    logic signed [31:0] acc;
    logic signed [15:0] res;
    logic [5:0]         res_idx;
    logic               res_valid;

    logic [4:0]         rd_idx, cap_idx;
    logic [8:0]         mac_idx;
    logic [5:0]         elem;
    logic [2:0]         tap;
    logic               cap_en, mac_en;
    logic signed [15:0] op_a;
    logic signed [12:0] op_b;
    logic signed [31:0] a_ext, b_ext, prod, sum;
    logic [17:0]        rd_addr, wr_addr;

    function automatic logic signed [12:0] mag(input logic [4:0] j);
        case (j)
            5'd0:    return 13'sd2048;
            5'd1:    return 13'sd2009;
            5'd2:    return 13'sd1892;
            5'd3:    return 13'sd1703;
            5'd4:    return 13'sd1448;
            5'd5:    return 13'sd1138;
            5'd6:    return 13'sd784;
            5'd7:    return 13'sd400;
            default: return 13'sd0;
        endcase
    endfunction

    // cos((2n+1)k*pi/16) folded onto the first quadrant; the angle index is taken mod 32.
    function automatic logic signed [12:0] c_coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0] i;
        i = 5'({n, 1'b1}) * 5'(k);
        if (k == 3'd0)       return 13'sd1448;
        else if (i <= 5'd8)  return mag(i);
        else if (i <= 5'd16) return -mag(5'd16 - i);
        else if (i <= 5'd24) return -mag(i - 5'd16);
        else                 return mag(5'd0 - i);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)       return 16'sh7FFF;
        else if (v < -32'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    // cyc holds the number of the edge about to occur, counted from the Start edge.
    assign rd_idx  = 5'(cyc - 11'd1);
    assign cap_idx = 5'(cyc - 11'd3);
    assign mac_idx = (state == S_CS) ? 9'(cyc - 11'd547) : 9'(cyc - 11'd35);
    assign elem    = mac_idx[8:3];
    assign tap     = mac_idx[2:0];
    assign cap_en  = (state == S_FETCH && cyc >= 11'd3) || state == S_FETCH_DRAIN;
    assign mac_en  = state == S_CT || (state == S_CS && cyc <= 11'd1058);

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state == S_CS) begin
            op_a = t_mem[{tap, elem[2:0]}];
            op_b = c_coef(elem[5:3], tap);
        end else begin
            op_a = {8'b0, s_mem[{elem[5:3], tap}]};
            op_b = c_coef(elem[2:0], tap);
        end
    end

    assign a_ext   = {{16{op_a[15]}}, op_a};
    assign b_ext   = {{19{op_b[12]}}, op_b};
    assign prod    = a_ext * b_ext;
    assign sum     = ((tap == 3'd0) ? 32'sd0 : acc) + prod;
    assign rd_addr = pix_base + 18'(rd_idx[4:2]) * 18'(pix_stride) + 18'(rd_idx[1:0]);
    assign wr_addr = coef_base + 18'(res_idx[5:3]) * 18'(coef_stride) + 18'(res_idx[2:0]);

    always_ff @(posedge Clock) begin
        if (cap_en) begin
            s_mem[{cap_idx, 1'b0}] <= SRAM_read_data[15:8];
            s_mem[{cap_idx, 1'b1}] <= SRAM_read_data[7:0];
        end
        if (mac_en) begin
            acc <= sum;
            if (tap == 3'd7) begin
                if (state == S_CT) begin
                    t_mem[elem] <= sat16(sum >>> 8);
                end else begin
                    res     <= sat16(sum >>> 16);
                    res_idx <= elem;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= S_IDLE;
            cyc             <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            res_valid       <= 1'b0;
        end else begin
            Done      <= 1'b0;
            SRAM_we_n <= 1'b1;
            res_valid <= mac_en && state == S_CS && tap == 3'd7;
            if (state != S_IDLE) cyc <= cyc + 11'd1;
            // A finished coefficient is written on the edge after its last MAC.
            if (res_valid) begin
                SRAM_we_n       <= 1'b0;
                SRAM_write_data <= res;
                SRAM_address    <= wr_addr;
            end
            case (state)
                S_IDLE: if (Start) begin
                    pix_base    <= Pixel_base;
                    pix_stride  <= Pixel_stride;
                    coef_base   <= Coeff_base;
                    coef_stride <= Coeff_stride;
                    cyc         <= 11'd1;
                    Busy        <= 1'b1;
                    state       <= S_FETCH;
                end
                S_FETCH: begin
                    SRAM_address <= rd_addr;
                    if (cyc == 11'd32) state <= S_FETCH_DRAIN;
                end
                S_FETCH_DRAIN: if (cyc == 11'd34) state <= S_CT;
                S_CT:          if (cyc == 11'd546) state <= S_CS;
                S_CS:          if (cyc == 11'd1059) state <= S_DONE;
                S_DONE: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m2_fdct_block_encoder.sv
// Directed bench for the forward DCT block encoder with a 2-cycle-latency SRAM model.
module tb_m2_fdct_block_encoder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [17:0] Pixel_base = '0;
    logic [8:0]  Pixel_stride = '0;
    logic [17:0] Coeff_base = '0;
    logic [8:0]  Coeff_stride = '0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        Busy;
    logic        Done;

    m2_fdct_block_encoder dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .Pixel_base(Pixel_base), .Pixel_stride(Pixel_stride),
        .Coeff_base(Coeff_base), .Coeff_stride(Coeff_stride),
        .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [0:4095];
    always @(posedge Clock) SRAM_read_data <= mem[SRAM_address[11:0]];

    int edge_cnt = 0;
    always @(posedge Clock) edge_cnt++;

    int          e0 = 0;
    bit          logging = 0;
    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          we_q[$];
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always @(negedge Clock) begin
        if (logging && SRAM_we_n === 1'b0) begin
            wa_q.push_back(SRAM_address);
            wd_q.push_back(SRAM_write_data);
            we_q.push_back(edge_cnt - e0);
        end
    end

    task automatic fill_const(input logic [15:0] w);
        for (int i = 0; i < 4096; i++) mem[i] = w;
    endtask

    task automatic start_block(input logic [17:0] pb, input logic [8:0] ps,
                               input logic [17:0] cb, input logic [8:0] cs);
        @(negedge Clock);
        Pixel_base = pb; Pixel_stride = ps; Coeff_base = cb; Coeff_stride = cs;
        wa_q.delete(); wd_q.delete(); we_q.delete();
        logging = 1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        e0 = edge_cnt;
    endtask

    task automatic wait_done(output int rel);
        rel = -1;
        for (int i = 0; i < 1300; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                rel = edge_cnt - e0;
                break;
            end
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint c_ref(input int k, input int n);
        real a;
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        return longint'($rtoi($floor(4096.0 * a * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0) + 0.5)));
    endfunction

    // Reference 2-D DCT straight from the definition, read from the SRAM model.
    function automatic void model_block(input int pb, input int ps);
        longint s [8][8];
        longint t [8][8];
        longint a;
        logic [15:0] w;
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) begin
                w = mem[pb + r * ps + n / 2];
                s[r][n] = (n % 2 == 0) ? longint'(w[15:8]) : longint'(w[7:0]);
            end
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                a = 0;
                for (int n = 0; n < 8; n++) a += s[r][n] * c_ref(k, n);
                t[r][k] = sat16(a >>> 8);
            end
        exp_q.delete();
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 8; c++) begin
                a = 0;
                for (int r = 0; r < 8; r++) a += c_ref(k, r) * t[r][c];
                exp_q.push_back(16'(sat16(a >>> 16)));
            end
    endfunction

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        n_checks++; if (SRAM_address !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %0d need 0", SRAM_address); end
        n_checks++; if (SRAM_write_data !== 16'd0) begin n_fail++; $display("FAIL reset_wdata: got %0d need 0", SRAM_write_data); end
        n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b need 1", SRAM_we_n); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", Done); end
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_zero_block;
        int rel;
        logic [17:0] ea;
        fill_const(16'h0000);
        start_block(18'd0, 9'd160, 18'd76800, 9'd320);
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b need 1", Busy); end
        wait_done(rel);
        logging = 0;
        n_checks++; if (rel != 1060) begin n_fail++; $display("FAIL zero_done_edge: got %0d need 1060", rel); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_end: got %b need 0", Busy); end
        n_checks++; if (wa_q.size() != 64) begin n_fail++; $display("FAIL zero_count: got %0d need 64", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 64; i++) begin
            ea = 18'(76800 + (i / 8) * 320 + i % 8);
            n_checks++;
            if (wa_q[i] !== ea || wd_q[i] !== 16'd0 || we_q[i] != 555 + 8 * i) begin
                n_fail++;
                $display("FAIL zero_write[%0d]: got addr %0d data %0d edge %0d need addr %0d data 0 edge %0d",
                         i, wa_q[i], wd_q[i], we_q[i], ea, 555 + 8 * i);
            end
        end
    endtask

    task automatic test_full_white;
        int rel;
        logic [17:0] ea;
        fill_const(16'hFFFF);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back((i == 0) ? 16'd2039 : 16'd0);
        start_block(18'd8, 9'd80, 18'd1000, 9'd160);
        wait_done(rel);
        logging = 0;
        n_checks++; if (rel != 1060) begin n_fail++; $display("FAIL white_done_edge: got %0d need 1060", rel); end
        n_checks++; if (wa_q.size() != 64) begin n_fail++; $display("FAIL white_count: got %0d need 64", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 64; i++) begin
            ea = 18'(1000 + (i / 8) * 160 + i % 8);
            n_checks++;
            if (wa_q[i] !== ea || wd_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL white_coef[%0d]: got addr %0d data %0d need addr %0d data %0d",
                         i, wa_q[i], $signed(wd_q[i]), ea, $signed(exp_q[i]));
            end
        end
    endtask

    task automatic test_mid_grey;
        int rel;
        fill_const(16'h8080);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back((i == 0) ? 16'd1023 : 16'd0);
        start_block(18'd0, 9'd160, 18'd76800, 9'd320);
        wait_done(rel);
        logging = 0;
        n_checks++; if (rel != 1060) begin n_fail++; $display("FAIL grey_done_edge: got %0d need 1060", rel); end
        n_checks++; if (wd_q.size() != 64) begin n_fail++; $display("FAIL grey_count: got %0d need 64", wd_q.size()); end
        for (int i = 0; i < wd_q.size() && i < 64; i++) begin
            n_checks++;
            if (wd_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL grey_coef[%0d]: got %0d need %0d", i, $signed(wd_q[i]), $signed(exp_q[i]));
            end
        end
        for (int r = 0; r < 8; r++) begin
            n_checks++;
            if (dut.t_mem[r * 8] !== 16'sd5792) begin
                n_fail++;
                $display("FAIL grey_t[%0d][0]: got %0d need 5792", r, dut.t_mem[r * 8]);
            end
        end
    endtask

    task automatic test_addressing;
        int rel;
        logic [17:0] ea;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom_range(0, 65535));
        model_block(4, 160);
        start_block(18'd4, 9'd160, 18'd200000, 9'd320);
        for (int n = 1; n <= 32; n++) begin
            @(negedge Clock);
            ea = 18'(4 + ((n - 1) / 4) * 160 + (n - 1) % 4);
            n_checks++;
            if (SRAM_address !== ea || SRAM_we_n !== 1'b1) begin
                n_fail++;
                $display("FAIL read_addr[E%0d]: got %0d we_n %b need %0d we_n 1", n, SRAM_address, SRAM_we_n, ea);
            end
        end
        wait_done(rel);
        logging = 0;
        n_checks++; if (rel != 1060) begin n_fail++; $display("FAIL addr_done_edge: got %0d need 1060", rel); end
        n_checks++; if (wa_q.size() != 64) begin n_fail++; $display("FAIL addr_count: got %0d need 64", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 64; i++) begin
            ea = 18'(200000 + (i / 8) * 320 + i % 8);
            n_checks++;
            if (wa_q[i] !== ea || wd_q[i] !== exp_q[i] || we_q[i] != 555 + 8 * i) begin
                n_fail++;
                $display("FAIL addr_coef[%0d]: got addr %0d data %0d edge %0d need addr %0d data %0d edge %0d",
                         i, wa_q[i], $signed(wd_q[i]), we_q[i], ea, $signed(exp_q[i]), 555 + 8 * i);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int rel;
        fill_const(16'h0000);
        start_block(18'd0, 9'd160, 18'd76800, 9'd320);
        repeat (99) @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        wait_done(rel);
        logging = 0;
        n_checks++; if (rel != 1060) begin n_fail++; $display("FAIL restart_done_edge: got %0d need 1060", rel); end
        n_checks++; if (we_q.size() != 64) begin n_fail++; $display("FAIL restart_count: got %0d need 64", we_q.size()); end
        for (int i = 0; i < we_q.size() && i < 64; i++) begin
            n_checks++;
            if (we_q[i] != 555 + 8 * i || wa_q[i] !== 18'(76800 + (i / 8) * 320 + i % 8)) begin
                n_fail++;
                $display("FAIL restart_write[%0d]: got edge %0d addr %0d need edge %0d", i, we_q[i], wa_q[i], 555 + 8 * i);
            end
        end
        repeat (20) @(negedge Clock);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got busy %b need 0", Busy); end
    endtask

    task automatic test_reset_mid_block;
        int rel;
        int late;
        fill_const(16'hFFFF);
        start_block(18'd0, 9'd160, 18'd76800, 9'd320);
        repeat (600) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL midreset_we_n: got %b need 1", SRAM_we_n); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b need 0", Busy); end
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (30) @(negedge Clock);
        logging = 0;
        late = 0;
        foreach (we_q[i]) if (we_q[i] >= 601) late++;
        n_checks++; if (late != 0) begin n_fail++; $display("FAIL midreset_writes: got %0d late writes need 0", late); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy %b need 0", Busy); end
        start_block(18'd0, 9'd160, 18'd76800, 9'd320);
        wait_done(rel);
        logging = 0;
        n_checks++; if (rel != 1060) begin n_fail++; $display("FAIL after_reset_done_edge: got %0d need 1060", rel); end
        n_checks++; if (wd_q.size() != 64) begin n_fail++; $display("FAIL after_reset_count: got %0d need 64", wd_q.size()); end
        n_checks++;
        if (wd_q.size() == 0 || wd_q[0] !== 16'd2039) begin
            n_fail++;
            $display("FAIL after_reset_dc: got %0d need 2039", (wd_q.size() == 0) ? -1 : int'($signed(wd_q[0])));
        end
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_full_white();
        test_mid_grey();
        test_addressing();
        test_start_while_busy();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
